mod_n_counter: RTL and testbench

Parametrised modulo-N up/down counter with synchronous load, count enable, direction control, one-shot mode and cascade outputs. It generalises the fixed mod-12 4-bit loadable counter to any modulus and width. It serves as the standard counter primitive for dividers, timers and chained multi-digit counters. A single clock domain is used, and all state is held in registers.

---
 rtl/mod_n_counter.sv | 111 +++++++++++
 tb/tb_mod_n_counter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mod_n_counter.sv
// Parametrised modulo-N up/down counter with synchronous load, one-shot halt and
// cascade outputs (combinational tc for chaining, registered wrap pulse).
module mod_n_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] l_data,
  output logic [WIDTH-1:0] ctr,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             load_err
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ctr_q, ctr_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             load_err_q, load_err_d;

  logic [WIDTH-1:0] term_s;
  logic             at_term_s;
  logic             load_ok_s;
  logic             ctr_bad_s;

  assign term_s    = up ? MAX_C : {WIDTH{1'b0}};
  assign at_term_s = (ctr_q == term_s);
  // Comparisons are widened by one bit so MODULUS == 2**WIDTH stays representable.
  assign load_ok_s = ({1'b0, l_data} < MOD_X);
  assign ctr_bad_s = ({1'b0, ctr_q} >= MOD_X);

  assign tc = en & ~done_q & at_term_s;

  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    done_d     = done_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok_s) begin
        ctr_d   = l_data;
        state_d = S_RUN;
        done_d  = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      case (state_q)
        S_RUN: begin
          if (ctr_bad_s) begin
            ctr_d = {WIDTH{1'b0}};
          end else if (!at_term_s) begin
            ctr_d = up ? (ctr_q + WIDTH'(1)) : (ctr_q - WIDTH'(1));
          end else if (!oneshot) begin
            ctr_d  = up ? {WIDTH{1'b0}} : MAX_C;
            wrap_d = 1'b1;
          end else begin
            state_d = S_HALT;
            done_d  = 1'b1;
          end
        end
        S_HALT: begin
          ctr_d = ctr_q;
        end
        default: begin
          state_d = S_RUN;
          done_d  = 1'b0;
        end
      endcase
    end else begin
      ctr_d = ctr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      ctr_q      <= {WIDTH{1'b0}};
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign ctr      = ctr_q;
  assign wrap     = wrap_q;
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed scoreboard bench for mod_n_counter (WIDTH=4, MODULUS=12), including a
// two-stage cascade where the high counter is enabled by the low counter's tc.
module tb_mod_n_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       oneshot;
  logic       load;
  logic [3:0] l_data;

  logic [3:0] ctr_lo, ctr_hi;
  logic       tc_lo, tc_hi;
  logic       wrap_lo, wrap_hi;
  logic       done_lo, done_hi;
  logic       lerr_lo, lerr_hi;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  mod_n_counter #(.WIDTH(4), .MODULUS(12)) u_lo (
    .clk(clk), .rst(rst), .en(en), .up(up), .oneshot(oneshot), .load(load),
    .l_data(l_data), .ctr(ctr_lo), .tc(tc_lo), .wrap(wrap_lo), .done(done_lo),
    .load_err(lerr_lo)
  );

  mod_n_counter #(.WIDTH(4), .MODULUS(12)) u_hi (
    .clk(clk), .rst(rst), .en(tc_lo), .up(1'b1), .oneshot(1'b0), .load(1'b0),
    .l_data(4'd0), .ctr(ctr_hi), .tc(tc_hi), .wrap(wrap_hi), .done(done_hi),
    .load_err(lerr_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_v(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t x;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0d with no expected value queued", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", x.tag, obs, x.exp);
      end
    end
  endtask

  // One clock of stimulus on the low counter; tc is checked before the edge.
  task automatic cyc(input logic e, input logic u, input logic os, input logic ld,
                     input logic [3:0] d, input logic exp_tc, input logic [3:0] exp_ctr,
                     input logic exp_wrap, input logic exp_done, input logic exp_lerr,
                     input string tag);
    @(negedge clk);
    en = e; up = u; oneshot = os; load = ld; l_data = d;
    expect_v({tag, "_tc"}, 32'(exp_tc));
    #1;
    pop_check(32'(tc_lo));
    expect_v({tag, "_ctr"}, 32'(exp_ctr));
    expect_v({tag, "_wrap"}, 32'(exp_wrap));
    expect_v({tag, "_done"}, 32'(exp_done));
    expect_v({tag, "_lerr"}, 32'(exp_lerr));
    @(posedge clk);
    #1;
    pop_check(32'(ctr_lo));
    pop_check(32'(wrap_lo));
    pop_check(32'(done_lo));
    pop_check(32'(lerr_lo));
  endtask

  initial begin
    int lo_m;
    int hi_m;
    rst = 1'b1; en = 1'b0; up = 1'b0; oneshot = 1'b0; load = 1'b0; l_data = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    expect_v("rst_ctr", 32'd0);
    expect_v("rst_wrap", 32'd0);
    expect_v("rst_done", 32'd0);
    expect_v("rst_lerr", 32'd0);
    expect_v("rst_tc_idle", 32'd0);
    pop_check(32'(ctr_lo));
    pop_check(32'(wrap_lo));
    pop_check(32'(done_lo));
    pop_check(32'(lerr_lo));
    pop_check(32'(tc_lo));
    en = 1'b1; up = 1'b0;
    #1;
    expect_v("rst_tc_down", 32'd1);
    pop_check(32'(tc_lo));
    @(negedge clk);
    en = 1'b0; rst = 1'b0;

    // Free-running up count 0..11 then back to 0, one step past the wrap.
    for (int k = 0; k < 13; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, (k == 11), 4'((k + 1) % 12),
          (k == 11), 1'b0, 1'b0, "up");
    end

    // Down count from 1 through the 0 -> 11 wrap.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, "dn1");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd11, 1'b1, 1'b0, 1'b0, "dn0");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0, "dn11");

    // Load wins over enable; out-of-range load is rejected.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd7,  1'b0, 4'd7, 1'b0, 1'b0, 1'b0, "ld7");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd8, 1'b0, 1'b0, 1'b0, "ld_c8");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd9, 1'b0, 1'b0, 1'b0, "ld_c9");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1, "ld13");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd9, 1'b0, 1'b0, 1'b0, "lerr_clr");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd12, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1, "ld12");

    // One-shot: halts at 11 without wrapping; only load leaves HALT.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 1'b0, 4'd9,  1'b0, 1'b0, 1'b0, "os_ld9");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0, "os10");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, "os11");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd11, 1'b0, 1'b1, 1'b0, "os_halt");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd11, 1'b0, 1'b1, 1'b0, "os_hold");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd11, 1'b0, 1'b1, 1'b0, "os_clr");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0, "os_ld2");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, "os_run3");

    // Asynchronous reset between edges at ctr=6.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, "ar4");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, "ar5");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, "ar6");
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    expect_v("arst_ctr", 32'd0);
    #1;
    pop_check(32'(ctr_lo));
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset while halted.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'd10, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0, "ah_ld10");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd11, 1'b0, 1'b0, 1'b0, "ah11");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd11, 1'b0, 1'b1, 1'b0, "ah_halt");
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    expect_v("ahrst_done", 32'd0);
    expect_v("ahrst_ctr", 32'd0);
    #1;
    pop_check(32'(done_lo));
    pop_check(32'(ctr_lo));
    @(negedge clk);
    rst = 1'b0; oneshot = 1'b0;

    // Cascade: high counter steps on each low wrap; 144 steps return to 0/0.
    lo_m = 0;
    hi_m = 0;
    for (int i = 0; i < 144; i++) begin
      @(negedge clk);
      en = 1'b1; up = 1'b1; load = 1'b0;
      expect_v("cas_tc_lo", 32'(lo_m == 11));
      #1;
      pop_check(32'(tc_lo));
      expect_v("cas_wrap_lo", 32'(lo_m == 11));
      expect_v("cas_wrap_hi", 32'((lo_m == 11) && (hi_m == 11)));
      if (lo_m == 11) hi_m = (hi_m + 1) % 12;
      lo_m = (lo_m + 1) % 12;
      expect_v("cas_ctr_lo", 32'(lo_m));
      expect_v("cas_ctr_hi", 32'(hi_m));
      @(posedge clk);
      #1;
      pop_check(32'(wrap_lo));
      pop_check(32'(wrap_hi));
      pop_check(32'(ctr_lo));
      pop_check(32'(ctr_hi));
    end
    expect_v("cas_final_lo", 32'd0);
    expect_v("cas_final_hi", 32'd0);
    pop_check(32'(ctr_lo));
    pop_check(32'(ctr_hi));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
